// File: rtl/writeback_stage_pkg.sv
// Shared core constants: datapath width, opcodes, writeback source selects,
// and the writeback sequencer state encoding.
package writeback_stage_pkg;

  localparam int unsigned CORE_DW = 16;

  // Opcode field inst[15:12]
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;

  // Writeback data source
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC1 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  // Sequencer states
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_LM_BURST = 1'b1;

endpackage

// File: rtl/lm_priority_enc.sv
// Lowest-set-bit encoder for 8-bit register masks (LM/SM sequencing).
module lm_priority_enc (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       any_set
);

  // Scan from the top so the lowest set bit is the last one to win
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

  assign any_set = |mask;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: registers memory-stage results, drives the register
// file write port and R7 (PC) update, sequences LM bursts, publishes a
// forwarding tap and counts retired instructions.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DW        = CORE_DW,
  parameter logic [3:0]  LM_OPCODE = OP_LM
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          lm_beat_in,
  input  logic          flush_in,
  input  logic [15:0]   inst_word_in,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] alu_result_in,
  input  logic [DW-1:0] mem_data_in,
  input  logic [2:0]    dest_addr_in,
  input  logic [1:0]    wb_sel_in,
  input  logic          reg_write_in,
  output logic [2:0]    rf_a3,
  output logic [DW-1:0] d_in3_wb,
  output logic          reg_write,
  output logic          R7_write,
  output logic [DW-1:0] d_R7,
  output logic          fwd_valid,
  output logic [2:0]    fwd_addr,
  output logic [DW-1:0] fwd_data,
  output logic [15:0]   retire_count
);

  logic [0:0]    state_q, state_d;
  logic [7:0]    mask_q, mask_d;
  logic [DW-1:0] pc_q, pc_d;
  logic          r7_loaded_q, r7_loaded_d;
  logic          ready_q;
  logic [2:0]    rf_a3_q, rf_a3_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          reg_write_q, reg_write_d;
  logic          r7_write_q, r7_write_d;
  logic [DW-1:0] d_r7_q, d_r7_d;
  logic [15:0]   retire_q, retire_d;

  logic [2:0]    lowest_idx;
  logic          mask_any;
  logic [7:0]    lowest_onehot;
  logic          accept;
  logic          is_lm;
  logic [DW-1:0] sel_data;
  logic          unused_inst;

  assign unused_inst = ^inst_word_in[11:9];

  lm_priority_enc u_lm_enc (
    .mask    (mask_q),
    .idx     (lowest_idx),
    .any_set (mask_any)
  );

  assign lowest_onehot = 8'b1 << lowest_idx;
  assign is_lm         = (inst_word_in[15:12] == LM_OPCODE);

  // Burst with an empty mask is the retire cycle, so nothing is accepted then
  assign in_ready = ready_q & ((state_q == ST_IDLE) | (lm_beat_in & mask_any));
  assign accept   = in_valid & in_ready;

  // Writeback source mux
  always_comb begin
    unique case (wb_sel_in)
      WB_SEL_ALU: sel_data = alu_result_in;
      WB_SEL_MEM: sel_data = mem_data_in;
      WB_SEL_PC1: sel_data = pc_in + DW'(1);
      default:    sel_data = DW'({inst_word_in[8:0], 7'b0});
    endcase
  end

  // Next-state: flush dominates, then IDLE accept, then LM beat/retire
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    pc_d        = pc_q;
    r7_loaded_d = r7_loaded_q;
    rf_a3_d     = rf_a3_q;
    wdata_d     = wdata_q;
    reg_write_d = 1'b0;
    r7_write_d  = 1'b0;
    d_r7_d      = d_r7_q;
    retire_d    = retire_q;

    if (flush_in) begin
      state_d     = ST_IDLE;
      mask_d      = 8'h00;
      r7_loaded_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      // Stray LM beats in IDLE are accepted and dropped
      if (accept && !lm_beat_in) begin
        if (is_lm) begin
          pc_d        = pc_in;
          r7_loaded_d = 1'b0;
          if (inst_word_in[7:0] == 8'h00) begin
            r7_write_d = 1'b1;
            d_r7_d     = pc_in + DW'(1);
            retire_d   = retire_q + 16'd1;
          end else begin
            mask_d  = inst_word_in[7:0];
            state_d = ST_LM_BURST;
          end
        end else begin
          if (reg_write_in && dest_addr_in != 3'd7) begin
            reg_write_d = 1'b1;
            rf_a3_d     = dest_addr_in;
            wdata_d     = sel_data;
          end
          r7_write_d = 1'b1;
          d_r7_d     = (reg_write_in && dest_addr_in == 3'd7) ? sel_data : pc_in + DW'(1);
          retire_d   = retire_q + 16'd1;
        end
      end
    end else begin
      if (!mask_any) begin
        // Mask drained on the previous beat: retire the LM
        state_d     = ST_IDLE;
        r7_loaded_d = 1'b0;
        retire_d    = retire_q + 16'd1;
        if (!r7_loaded_q) begin
          r7_write_d = 1'b1;
          d_r7_d     = pc_q + DW'(1);
        end
      end else if (accept) begin
        mask_d = mask_q & ~lowest_onehot;
        if (lowest_idx == 3'd7) begin
          r7_write_d  = 1'b1;
          d_r7_d      = mem_data_in;
          r7_loaded_d = 1'b1;
        end else begin
          reg_write_d = 1'b1;
          rf_a3_d     = lowest_idx;
          wdata_d     = mem_data_in;
        end
      end
    end
  end

  // State and registered write-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= 8'h00;
      pc_q        <= '0;
      r7_loaded_q <= 1'b0;
      ready_q     <= 1'b0;
      rf_a3_q     <= 3'd0;
      wdata_q     <= '0;
      reg_write_q <= 1'b0;
      r7_write_q  <= 1'b0;
      d_r7_q      <= '0;
      retire_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      pc_q        <= pc_d;
      r7_loaded_q <= r7_loaded_d;
      ready_q     <= 1'b1;
      rf_a3_q     <= rf_a3_d;
      wdata_q     <= wdata_d;
      reg_write_q <= reg_write_d;
      r7_write_q  <= r7_write_d;
      d_r7_q      <= d_r7_d;
      retire_q    <= retire_d;
    end
  end

  assign rf_a3        = rf_a3_q;
  assign d_in3_wb     = wdata_q;
  assign reg_write    = reg_write_q;
  assign R7_write     = r7_write_q;
  assign d_R7         = d_r7_q;
  assign retire_count = retire_q;

  // Forwarding tap: an R7 write takes the tap when present
  assign fwd_valid = reg_write_q | r7_write_q;
  assign fwd_addr  = r7_write_q ? 3'd7 : rf_a3_q;
  assign fwd_data  = r7_write_q ? d_r7_q : wdata_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, lm_beat_in, flush_in;
  logic [15:0] inst_word_in, pc_in, alu_result_in, mem_data_in;
  logic [2:0]  dest_addr_in;
  logic [1:0]  wb_sel_in;
  logic        reg_write_in;
  logic [2:0]  rf_a3;
  logic [15:0] d_in3_wb;
  logic        reg_write, R7_write;
  logic [15:0] d_R7;
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic [15:0] retire_count;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .lm_beat_in    (lm_beat_in),
    .flush_in      (flush_in),
    .inst_word_in  (inst_word_in),
    .pc_in         (pc_in),
    .alu_result_in (alu_result_in),
    .mem_data_in   (mem_data_in),
    .dest_addr_in  (dest_addr_in),
    .wb_sel_in     (wb_sel_in),
    .reg_write_in  (reg_write_in),
    .rf_a3         (rf_a3),
    .d_in3_wb      (d_in3_wb),
    .reg_write     (reg_write),
    .R7_write      (R7_write),
    .d_R7          (d_R7),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_valid      = 1'b0;
    lm_beat_in    = 1'b0;
    flush_in      = 1'b0;
    inst_word_in  = 16'h0000;
    pc_in         = 16'h0000;
    alu_result_in = 16'h0000;
    mem_data_in   = 16'h0000;
    dest_addr_in  = 3'd0;
    wb_sel_in     = 2'b00;
    reg_write_in  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the accept edge
  task automatic drive(input logic beat, input logic [15:0] inst, input logic [15:0] pc,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [2:0] dest,
                       input logic [1:0] sel, input logic rw);
    in_valid      = 1'b1;
    lm_beat_in    = beat;
    inst_word_in  = inst;
    pc_in         = pc;
    alu_result_in = alu;
    mem_data_in   = mem;
    dest_addr_in  = dest;
    wb_sel_in     = sel;
    reg_write_in  = rw;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({reg_write, R7_write, fwd_valid, in_ready} !== 4'b0000) begin
      $display("FAIL reset_enables: got %b required 0000", {reg_write, R7_write, fwd_valid, in_ready});
      n_fail++;
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL ready_before_clock: got %b required 0", in_ready); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL ready_after_clock: got %b required 1", in_ready); n_fail++;
    end
    drive(1'b0, 16'h0000, 16'h0010, 16'h1234, 16'h0000, 3'd3, 2'b00, 1'b1);
    n_checks++;
    if ({reg_write, rf_a3, d_in3_wb} !== {1'b1, 3'd3, 16'h1234}) begin
      $display("FAIL add_write: got we=%b a3=%0d d=%h required we=1 a3=3 d=1234",
               reg_write, rf_a3, d_in3_wb);
      n_fail++;
    end
    n_checks++;
    if ({R7_write, d_R7, retire_count} !== {1'b1, 16'h0011, 16'd1}) begin
      $display("FAIL add_r7: got r7w=%b dR7=%h ret=%0d required r7w=1 dR7=0011 ret=1",
               R7_write, d_R7, retire_count);
      n_fail++;
    end
    // Reset asserted mid-cycle clears outputs without a clock edge
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({reg_write, R7_write, rf_a3, d_in3_wb, d_R7, retire_count, fwd_valid, fwd_addr,
         fwd_data, in_ready} !== '0) begin
      $display("FAIL async_reset: got we=%b r7w=%b a3=%0d d=%h dR7=%h ret=%0d fv=%b fa=%0d fd=%h rdy=%b required all 0",
               reg_write, R7_write, rf_a3, d_in3_wb, d_R7, retire_count, fwd_valid, fwd_addr,
               fwd_data, in_ready);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_imm_pc();
    drive(1'b0, 16'h31FF, 16'h0050, 16'h0000, 16'h0000, 3'd2, 2'b11, 1'b1);
    n_checks++;
    if ({reg_write, rf_a3, d_in3_wb, retire_count} !== {1'b1, 3'd2, 16'hFF80, 16'd1}) begin
      $display("FAIL imm9_pad: got we=%b a3=%0d d=%h ret=%0d required we=1 a3=2 d=ff80 ret=1",
               reg_write, rf_a3, d_in3_wb, retire_count);
      n_fail++;
    end
    drive(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 3'd4, 2'b10, 1'b1);
    n_checks++;
    if ({reg_write, rf_a3, d_in3_wb, d_R7, retire_count} !== {1'b1, 3'd4, 16'h0000, 16'h0000, 16'd2}) begin
      $display("FAIL pc1_wrap: got we=%b a3=%0d d=%h dR7=%h ret=%0d required we=1 a3=4 d=0000 dR7=0000 ret=2",
               reg_write, rf_a3, d_in3_wb, d_R7, retire_count);
      n_fail++;
    end
  endtask

  task automatic test_r7_dest();
    drive(1'b0, 16'h0000, 16'h0020, 16'h0040, 16'h0000, 3'd7, 2'b00, 1'b1);
    n_checks++;
    if ({reg_write, R7_write, d_R7, retire_count} !== {1'b0, 1'b1, 16'h0040, 16'd3}) begin
      $display("FAIL dest7: got we=%b r7w=%b dR7=%h ret=%0d required we=0 r7w=1 dR7=0040 ret=3",
               reg_write, R7_write, d_R7, retire_count);
      n_fail++;
    end
    n_checks++;
    if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 3'd7, 16'h0040}) begin
      $display("FAIL dest7_fwd: got fv=%b fa=%0d fd=%h required fv=1 fa=7 fd=0040",
               fwd_valid, fwd_addr, fwd_data);
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({reg_write, R7_write, fwd_valid, rf_a3, d_in3_wb} !== {3'b000, 3'd4, 16'h0000}) begin
      $display("FAIL bubble_hold: got we=%b r7w=%b fv=%b a3=%0d d=%h required 0 0 0 a3=4 d=0000",
               reg_write, R7_write, fwd_valid, rf_a3, d_in3_wb);
      n_fail++;
    end
  endtask

  task automatic test_lm();
    drive(1'b0, 16'h6085, 16'h0100, 16'h0000, 16'h0000, 3'd0, 2'b01, 1'b1);
    n_checks++;
    if ({reg_write, R7_write, retire_count} !== {2'b00, 16'd3}) begin
      $display("FAIL lm_capture: got we=%b r7w=%b ret=%0d required 0 0 ret=3",
               reg_write, R7_write, retire_count);
      n_fail++;
    end
    // Non-beat word during the burst must stall
    in_valid     = 1'b1;
    inst_word_in = 16'h0000;
    dest_addr_in = 3'd5;
    reg_write_in = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL lm_stall_ready: got %b required 0", in_ready); n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if ({reg_write, R7_write} !== 2'b00) begin
      $display("FAIL lm_stall_write: got we=%b r7w=%b required 0 0", reg_write, R7_write);
      n_fail++;
    end
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h000A, 3'd0, 2'b01, 1'b0);
    n_checks++;
    if ({reg_write, R7_write, rf_a3, d_in3_wb, fwd_valid, fwd_addr, fwd_data} !==
        {2'b10, 3'd0, 16'h000A, 1'b1, 3'd0, 16'h000A}) begin
      $display("FAIL lm_beat0: got we=%b r7w=%b a3=%0d d=%h fv=%b fa=%0d fd=%h required 1 0 a3=0 d=000a fv=1 fa=0 fd=000a",
               reg_write, R7_write, rf_a3, d_in3_wb, fwd_valid, fwd_addr, fwd_data);
      n_fail++;
    end
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h000B, 3'd0, 2'b01, 1'b0);
    n_checks++;
    if ({reg_write, R7_write, rf_a3, d_in3_wb, fwd_addr, fwd_data} !==
        {2'b10, 3'd2, 16'h000B, 3'd2, 16'h000B}) begin
      $display("FAIL lm_beat2: got we=%b r7w=%b a3=%0d d=%h fa=%0d fd=%h required 1 0 a3=2 d=000b fa=2 fd=000b",
               reg_write, R7_write, rf_a3, d_in3_wb, fwd_addr, fwd_data);
      n_fail++;
    end
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h000C, 3'd0, 2'b01, 1'b0);
    n_checks++;
    if ({reg_write, R7_write, d_R7, fwd_addr, fwd_data, retire_count} !==
        {2'b01, 16'h000C, 3'd7, 16'h000C, 16'd3}) begin
      $display("FAIL lm_beat7: got we=%b r7w=%b dR7=%h fa=%0d fd=%h ret=%0d required 0 1 dR7=000c fa=7 fd=000c ret=3",
               reg_write, R7_write, d_R7, fwd_addr, fwd_data, retire_count);
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({reg_write, R7_write, retire_count, in_ready} !== {2'b00, 16'd4, 1'b1}) begin
      $display("FAIL lm_retire: got we=%b r7w=%b ret=%0d rdy=%b required 0 0 ret=4 rdy=1",
               reg_write, R7_write, retire_count, in_ready);
      n_fail++;
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 16'h6006, 16'h0200, 16'h0000, 16'h0000, 3'd0, 2'b01, 1'b1);
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 3'd0, 2'b01, 1'b0);
    n_checks++;
    if ({reg_write, rf_a3, d_in3_wb} !== {1'b1, 3'd1, 16'h0011}) begin
      $display("FAIL flush_beat1: got we=%b a3=%0d d=%h required 1 a3=1 d=0011",
               reg_write, rf_a3, d_in3_wb);
      n_fail++;
    end
    flush_in = 1'b1;
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0022, 3'd0, 2'b01, 1'b0);
    n_checks++;
    if ({reg_write, R7_write, rf_a3, retire_count, in_ready} !== {2'b00, 3'd1, 16'd4, 1'b1}) begin
      $display("FAIL flush_kill: got we=%b r7w=%b a3=%0d ret=%0d rdy=%b required 0 0 a3=1 ret=4 rdy=1",
               reg_write, R7_write, rf_a3, retire_count, in_ready);
      n_fail++;
    end
    // Beat arriving in IDLE is dropped
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0033, 3'd0, 2'b01, 1'b0);
    n_checks++;
    if ({reg_write, R7_write, retire_count} !== {2'b00, 16'd4}) begin
      $display("FAIL idle_beat_drop: got we=%b r7w=%b ret=%0d required 0 0 ret=4",
               reg_write, R7_write, retire_count);
      n_fail++;
    end
    drive(1'b0, 16'h6000, 16'h0300, 16'h0000, 16'h0000, 3'd0, 2'b01, 1'b1);
    n_checks++;
    if ({reg_write, R7_write, d_R7, retire_count} !== {2'b01, 16'h0301, 16'd5}) begin
      $display("FAIL lm_mask0: got we=%b r7w=%b dR7=%h ret=%0d required 0 1 dR7=0301 ret=5",
               reg_write, R7_write, d_R7, retire_count);
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({R7_write, retire_count} !== {1'b0, 16'd5}) begin
      $display("FAIL lm_mask0_once: got r7w=%b ret=%0d required 0 ret=5", R7_write, retire_count);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 16'hFFFF - 5;
    in_valid     = 1'b1;
    inst_word_in = 16'h0000;
    dest_addr_in = 3'd5;
    wb_sel_in    = 2'b00;
    reg_write_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      alu_result_in = 16'(i);
      pc_in         = 16'(i);
      @(posedge clk);
      @(negedge clk);
      if (i < 3 || i == n - 1) begin
        n_checks++;
        if ({reg_write, rf_a3, d_in3_wb, fwd_valid, retire_count} !==
            {1'b1, 3'd5, 16'(i), 1'b1, 16'(6 + i)}) begin
          $display("FAIL b2b_%0d: got we=%b a3=%0d d=%h fv=%b ret=%0d required 1 a3=5 d=%h fv=1 ret=%0d",
                   i, reg_write, rf_a3, d_in3_wb, fwd_valid, retire_count, 16'(i), 16'(6 + i));
          n_fail++;
        end
      end
    end
    alu_result_in = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if ({retire_count, d_in3_wb} !== {16'h0000, 16'h7777}) begin
      $display("FAIL retire_wrap: got ret=%h d=%h required ret=0000 d=7777", retire_count, d_in3_wb);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_lm();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 3'd1, 2'b00, 1'b1);
    drive(1'b0, 16'h6003, 16'h0400, 16'h0000, 16'h0000, 3'd0, 2'b01, 1'b1);
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0044, 3'd0, 2'b01, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({reg_write, R7_write, retire_count} !== {2'b00, 16'd0}) begin
      $display("FAIL reset_mid_lm: got we=%b r7w=%b ret=%0d required 0 0 ret=0",
               reg_write, R7_write, retire_count);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Burst abandoned: a beat now lands in IDLE and is dropped
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0055, 3'd0, 2'b01, 1'b0);
    n_checks++;
    if ({reg_write, R7_write, retire_count} !== {2'b00, 16'd0}) begin
      $display("FAIL reset_mid_lm_idle: got we=%b r7w=%b ret=%0d required 0 0 ret=0",
               reg_write, R7_write, retire_count);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_imm_pc();
    test_r7_dest();
    test_lm();
    test_flush();
    test_back_to_back();
    test_reset_mid_lm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
